// File: rtl/tdm_scan_mux.sv
// N-channel, W-bit registered time-division mux with a round-robin dwell scanner.
// The scanner visits enabled channels in index order and spends DWELL cycles on each one.

module tdm_scan_lane #(
   parameter int W     = 8,
   parameter int SEL_W = 3,
   parameter int IDX   = 0
) (
   input  logic [W-1:0]     d,
   input  logic [SEL_W-1:0] ch,
   output logic [W-1:0]     q
);
   assign q = (ch == SEL_W'(IDX)) ? d : '0;
endmodule

module tdm_scan_mux #(
   parameter int N_CH  = 8,
   parameter int W     = 8,
   parameter int DWELL = 4,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH*W-1:0] din,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel_in,
   input  logic              sel_load,
   input  logic [N_CH-1:0]   en_mask,
   output logic [W-1:0]      y,
   output logic [SEL_W-1:0]  ch,
   output logic              y_valid,
   output logic              wrap
);
   typedef enum logic [1:0] {MANUAL, SCAN, HALT} state_t;

   localparam logic [7:0] LAST = 8'(DWELL - 1);

   state_t                  state_q, state_d;
   logic [7:0]              dwell_cnt, cnt_eff;
   logic                    scan, halt, load_ok, expire, scan_entry;
   logic [SEL_W-1:0]        nxt_ch;
   logic [SEL_W:0]          idx;
   logic                    found;
   logic [N_CH-1:0][W-1:0]  lane_q;
   logic [W-1:0]            sel_data;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= state_d;
      else     state_q <= state_d;
   end

   // Next state follows mode/en_mask directly so mode changes act in the same cycle
   always_comb begin
      state_d = MANUAL;
      if (mode) state_d = (en_mask == '0) ? HALT : SCAN;
   end

   // Output/control decode
   always_comb begin
      scan       = (state_d == SCAN);
      halt       = (state_d == HALT);
      scan_entry = scan && (state_q != SCAN);
      load_ok    = sel_load && (int'(sel_in) < N_CH);
      cnt_eff    = scan_entry ? '0 : dwell_cnt;
      expire     = (cnt_eff == LAST);
   end

   // Next enabled channel after ch, wrapping modulo N_CH; lands on ch itself if it is the only one
   always_comb begin
      nxt_ch = ch;
      found  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N_CH; i++) begin
         idx = {1'b0, ch} + (SEL_W+1)'(i);
         if (idx >= (SEL_W+1)'(N_CH)) idx = idx - (SEL_W+1)'(N_CH);
         if (!found && en_mask[idx[SEL_W-1:0]]) begin
            nxt_ch = idx[SEL_W-1:0];
            found  = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_lane
      tdm_scan_lane #(.W(W), .SEL_W(SEL_W), .IDX(k)) u_lane (
         .d  (din[k*W +: W]),
         .ch (ch),
         .q  (lane_q[k])
      );
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N_CH; k++) sel_data = sel_data | lane_q[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch        <= '0;
         dwell_cnt <= '0;
         wrap      <= 1'b0;
         y         <= '0;
         y_valid   <= 1'b0;
      end else begin
         y       <= sel_data;
         y_valid <= en_mask[ch] && !halt;
         wrap    <= 1'b0;
         if (load_ok) begin
            ch        <= sel_in;
            dwell_cnt <= '0;
         end else if (scan) begin
            if (expire) begin
               ch        <= nxt_ch;
               dwell_cnt <= '0;
               wrap      <= (nxt_ch <= ch);
            end else begin
               dwell_cnt <= cnt_eff + 8'd1;
            end
         end else begin
            dwell_cnt <= '0;
         end
      end
   end
endmodule
